// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   - arb_state_e : arbiter FSM state codes
//   - ARB_M0/ARB_M1 : owner / grant identifiers
//   - mem_req_t   : captured memory access (we, sel, addr, wdata)
package dmem_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   localparam logic ARB_M0 = 1'b0;
   localparam logic ARB_M1 = 1'b1;

   typedef struct packed {
      logic              we;
      logic [SEL_W-1:0]  sel;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way picker.
//   req0, req1  : level requests from M0 / M1
//   last        : id of the previously granted master
//   prio_mode   : 0 = alternate on ties, 1 = M0 wins ties
//   gnt_valid   : at least one request present
//   gnt_id      : chosen master (ARB_M0 / ARB_M1)
module rr_arb2
   import dmem_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   input  logic prio_mode,
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = req0 | req1;
      gnt_id    = ARB_M0;
      if (req0 && req1) begin
         gnt_id = prio_mode ? ARB_M0 : ~last;
      end else if (req1) begin
         gnt_id = ARB_M1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory slave port between the core (M0) and an external
// loader/debug master (M1). A granted access is captured, presented to the
// slave until it completes (or the watchdog expires), then answered with a
// one-cycle done pulse on the owning master.
//   clk, rst            : clock, synchronous active-high reset
//   m0_* / m1_*         : master request, attributes, read data, done pulse
//   s_*                 : slave request/attributes, read data, completion
//   hold_flag_o         : pipeline stall while a core access is outstanding
//   err_o               : watchdog abort flag, pulses with done
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned PRIO_MODE = 0,
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [SEL_W-1:0]  m0_sel_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic [DATA_W-1:0] m0_rdata_o,
   output logic              m0_done_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [SEL_W-1:0]  m1_sel_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              m1_done_o,
   output logic              s_req_o,
   output logic              s_we_o,
   output logic [SEL_W-1:0]  s_sel_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [DATA_W-1:0] s_wdata_o,
   input  logic [DATA_W-1:0] s_rdata_i,
   input  logic              s_rvalid_i,
   output logic              hold_flag_o,
   output logic              err_o
);

   localparam bit             WD_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   arb_state_e        state_q, state_d;
   logic              owner_q;
   logic              last_grant_q;
   logic [CNT_W-1:0]  cnt_q;
   mem_req_t          req_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   logic              gnt_valid;
   logic              gnt_id;
   logic              timeout_hit;
   mem_req_t          m0_pkt;
   mem_req_t          m1_pkt;

   rr_arb2 u_rr_arb2 (
      .req0      (m0_req_i),
      .req1      (m1_req_i),
      .last      (last_grant_q),
      .prio_mode (PRIO_MODE != 0),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   // Pack live master attributes for capture at grant time.
   always_comb begin
      m0_pkt = '{we: m0_we_i, sel: m0_sel_i, addr: m0_addr_i, wdata: m0_wdata_i};
      m1_pkt = '{we: m1_we_i, sel: m1_sel_i, addr: m1_addr_i, wdata: m1_wdata_i};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; rvalid takes precedence over the watchdog.
   always_comb begin
      state_d     = state_q;
      timeout_hit = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (gnt_valid) begin
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (s_rvalid_i) begin
               state_d = ARB_RESP;
            end else if (WD_EN && (cnt_q == CNT_LAST)) begin
               timeout_hit = 1'b1;
               state_d     = ARB_RESP;
            end
         end
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   // Capture registers, ownership and watchdog counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q      <= ARB_M0;
         last_grant_q <= ARB_M1;
         cnt_q        <= '0;
         req_q        <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (gnt_valid) begin
                  req_q        <= (gnt_id == ARB_M1) ? m1_pkt : m0_pkt;
                  owner_q      <= gnt_id;
                  last_grant_q <= gnt_id;
                  cnt_q        <= '0;
               end
            end
            ARB_BUSY: begin
               if (s_rvalid_i) begin
                  rdata_q <= req_q.we ? '0 : s_rdata_i;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ARB_RESP: begin
               err_q <= 1'b0;
            end
            default: begin
               err_q <= 1'b0;
            end
         endcase
      end
   end

   // Outputs decoded from registered state; only hold_flag_o sees a live input.
   always_comb begin
      s_req_o     = 1'b0;
      s_we_o      = 1'b0;
      s_sel_o     = '0;
      s_addr_o    = '0;
      s_wdata_o   = '0;
      m0_done_o   = 1'b0;
      m1_done_o   = 1'b0;
      m0_rdata_o  = '0;
      m1_rdata_o  = '0;
      err_o       = 1'b0;
      if (state_q == ARB_BUSY) begin
         s_req_o   = 1'b1;
         s_we_o    = req_q.we;
         s_sel_o   = req_q.sel;
         s_addr_o  = req_q.addr;
         s_wdata_o = req_q.wdata;
      end
      if (state_q == ARB_RESP) begin
         err_o = err_q;
         if (owner_q == ARB_M0) begin
            m0_done_o  = 1'b1;
            m0_rdata_o = rdata_q;
         end else begin
            m1_done_o  = 1'b1;
            m1_rdata_o = rdata_q;
         end
      end
      hold_flag_o = m0_req_i & ~((state_q == ARB_RESP) && (owner_q == ARB_M0));
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance (u_rr, watchdog 4)
// and a fixed-priority instance (u_fx). Inputs change 1 time unit after the
// rising edge; outputs are checked 1 unit later.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Round-robin instance signals
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [3:0]  m0_sel, m1_sel;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_done, m1_done;
   logic        s_req, s_we, s_rvalid, hold_flag, err;
   logic [3:0]  s_sel;
   logic [31:0] s_addr, s_wdata, s_rdata;

   // Fixed-priority instance signals
   logic        f_m0_req, f_m0_we, f_m1_req, f_m1_we;
   logic [3:0]  f_m0_sel, f_m1_sel;
   logic [31:0] f_m0_addr, f_m0_wdata, f_m1_addr, f_m1_wdata;
   logic [31:0] f_m0_rdata, f_m1_rdata;
   logic        f_m0_done, f_m1_done;
   logic        f_s_req, f_s_we, f_s_rvalid, f_hold_flag, f_err;
   logic [3:0]  f_s_sel;
   logic [31:0] f_s_addr, f_s_wdata, f_s_rdata;

   int errors = 0;
   int checks = 0;

   dmem_arbiter #(.PRIO_MODE(0), .TIMEOUT(4), .CNT_W(8)) u_rr (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_addr_i(m0_addr),
      .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata), .m0_done_o(m0_done),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_addr_i(m1_addr),
      .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata), .m1_done_o(m1_done),
      .s_req_o(s_req), .s_we_o(s_we), .s_sel_o(s_sel), .s_addr_o(s_addr),
      .s_wdata_o(s_wdata), .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid),
      .hold_flag_o(hold_flag), .err_o(err)
   );

   dmem_arbiter #(.PRIO_MODE(1), .TIMEOUT(255), .CNT_W(8)) u_fx (
      .clk(clk), .rst(rst),
      .m0_req_i(f_m0_req), .m0_we_i(f_m0_we), .m0_sel_i(f_m0_sel), .m0_addr_i(f_m0_addr),
      .m0_wdata_i(f_m0_wdata), .m0_rdata_o(f_m0_rdata), .m0_done_o(f_m0_done),
      .m1_req_i(f_m1_req), .m1_we_i(f_m1_we), .m1_sel_i(f_m1_sel), .m1_addr_i(f_m1_addr),
      .m1_wdata_i(f_m1_wdata), .m1_rdata_o(f_m1_rdata), .m1_done_o(f_m1_done),
      .s_req_o(f_s_req), .s_we_o(f_s_we), .s_sel_o(f_s_sel), .s_addr_o(f_s_addr),
      .s_wdata_o(f_s_wdata), .s_rdata_i(f_s_rdata), .s_rvalid_i(f_s_rvalid),
      .hold_flag_o(f_hold_flag), .err_o(f_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
   endtask

   task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
   endtask

   task automatic slave(input logic rv, input logic [31:0] data);
      s_rvalid = rv; s_rdata = data;
   endtask

   initial begin
      rst = 1'b1;
      drive0(0, 0, 0, 0); drive1(0, 0, 0, 0); slave(0, 0);
      m0_sel = 4'hF; m1_sel = 4'h3;
      f_m0_req = 0; f_m0_we = 0; f_m0_sel = 4'hF; f_m0_addr = 0; f_m0_wdata = 0;
      f_m1_req = 0; f_m1_we = 0; f_m1_sel = 4'h3; f_m1_addr = 0; f_m1_wdata = 0;
      f_s_rvalid = 0; f_s_rdata = 0;
      cyc(); cyc();

      // Reset state
      settle();
      chk("rst_s_req", 32'(s_req), 0);
      chk("rst_s_addr", s_addr, 0);
      chk("rst_m0_done", 32'(m0_done), 0);
      chk("rst_m1_done", 32'(m1_done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_f_s_req", 32'(f_s_req), 0);
      chk("rst_f_err", 32'(f_err), 0);
      m0_req = 1; settle();
      chk("rst_hold_follows_hi", 32'(hold_flag), 1);
      m0_req = 0; settle();
      chk("rst_hold_follows_lo", 32'(hold_flag), 0);

      // 1: single M0 read, minimum latency
      rst = 0;
      drive0(1, 0, 32'h100, 0); settle();
      chk("t1_n_hold", 32'(hold_flag), 1);
      chk("t1_n_sreq", 32'(s_req), 0);
      cyc();
      slave(1, 32'hDEADBEEF); settle();
      chk("t1_busy_sreq", 32'(s_req), 1);
      chk("t1_busy_addr", s_addr, 32'h100);
      chk("t1_busy_we", 32'(s_we), 0);
      chk("t1_busy_sel", 32'(s_sel), 32'hF);
      chk("t1_busy_hold", 32'(hold_flag), 1);
      chk("t1_busy_done", 32'(m0_done), 0);
      cyc();
      slave(0, 0); settle();
      chk("t1_resp_done", 32'(m0_done), 1);
      chk("t1_resp_rdata", m0_rdata, 32'hDEADBEEF);
      chk("t1_resp_hold", 32'(hold_flag), 0);
      chk("t1_resp_err", 32'(err), 0);
      chk("t1_resp_m1_done", 32'(m1_done), 0);
      chk("t1_resp_sreq", 32'(s_req), 0);
      drive0(0, 0, 0, 0);
      cyc(); settle();
      chk("t1_idle_done", 32'(m0_done), 0);
      chk("t1_idle_rdata", m0_rdata, 0);
      // stray rvalid in IDLE must be ignored
      slave(1, 32'h12345678);
      cyc();
      slave(0, 0); settle();
      chk("stray_rv_m0_done", 32'(m0_done), 0);
      chk("stray_rv_m1_done", 32'(m1_done), 0);
      chk("stray_rv_sreq", 32'(s_req), 0);

      // 2: tie after reset in round-robin mode, continuous writes
      rst = 1;
      cyc();
      rst = 0;
      drive0(1, 1, 32'h400, 32'h11111111);
      drive1(1, 1, 32'h800, 32'h22222222);
      for (int k = 0; k < 4; k++) begin
         logic own;
         own = logic'(k % 2);
         settle();
         chk("t2_idle_sreq", 32'(s_req), 0);
         cyc();
         slave(1, 32'hCAFEF00D); settle();
         chk("t2_busy_addr", s_addr, own ? 32'h800 : 32'h400);
         chk("t2_busy_wdata", s_wdata, own ? 32'h22222222 : 32'h11111111);
         chk("t2_busy_sel", 32'(s_sel), own ? 32'h3 : 32'hF);
         chk("t2_busy_we", 32'(s_we), 1);
         chk("t2_busy_hold", 32'(hold_flag), 1);
         cyc();
         slave(0, 0); settle();
         chk("t2_resp_m0_done", 32'(m0_done), own ? 0 : 1);
         chk("t2_resp_m1_done", 32'(m1_done), own ? 1 : 0);
         chk("t2_resp_m0_rdata", m0_rdata, 0);
         chk("t2_resp_m1_rdata", m1_rdata, 0);
         chk("t2_resp_hold", 32'(hold_flag), own ? 1 : 0);
         if (k == 3) begin
            drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
         end
         cyc();
      end

      // 3: fixed priority, M0 issues three back-to-back reads ahead of M1
      f_m0_req = 1; f_m0_addr = 32'h10;
      f_m1_req = 1; f_m1_addr = 32'h200;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("t3_idle_sreq", 32'(f_s_req), 0);
         cyc();
         f_s_rvalid = 1; f_s_rdata = 32'hA0000000 + 32'(k); settle();
         chk("t3_busy_addr", f_s_addr, 32'h10 + 32'(4 * k));
         chk("t3_busy_we", 32'(f_s_we), 0);
         chk("t3_busy_sel", 32'(f_s_sel), 32'hF);
         chk("t3_busy_wdata", f_s_wdata, 0);
         cyc();
         f_s_rvalid = 0; f_s_rdata = 0; settle();
         chk("t3_resp_m0_done", 32'(f_m0_done), 1);
         chk("t3_resp_m1_done", 32'(f_m1_done), 0);
         chk("t3_resp_rdata", f_m0_rdata, 32'hA0000000 + 32'(k));
         chk("t3_resp_hold", 32'(f_hold_flag), 0);
         if (k < 2) f_m0_addr = f_m0_addr + 32'h4;
         else f_m0_req = 0;
         cyc();
      end
      cyc();
      f_s_rvalid = 1; f_s_rdata = 32'hB0B0B0B0; settle();
      chk("t3_m1_addr", f_s_addr, 32'h200);
      cyc();
      f_s_rvalid = 0; f_s_rdata = 0; settle();
      chk("t3_m1_done", 32'(f_m1_done), 1);
      chk("t3_m1_rdata", f_m1_rdata, 32'hB0B0B0B0);
      chk("t3_m1_m0_done", 32'(f_m0_done), 0);
      f_m1_req = 0;
      cyc();

      // 4: watchdog abort after four BUSY cycles
      drive0(1, 0, 32'h300, 0);
      slave(0, 32'hFFFFFFFF);
      for (int i = 0; i < 4; i++) begin
         cyc(); settle();
         chk("t4_busy_sreq", 32'(s_req), 1);
         chk("t4_busy_addr", s_addr, 32'h300);
         chk("t4_busy_done", 32'(m0_done), 0);
         chk("t4_busy_err", 32'(err), 0);
      end
      cyc(); settle();
      chk("t4_resp_done", 32'(m0_done), 1);
      chk("t4_resp_err", 32'(err), 1);
      chk("t4_resp_rdata", m0_rdata, 0);
      chk("t4_resp_sreq", 32'(s_req), 0);
      drive0(0, 0, 0, 0);
      cyc(); settle();
      chk("t4_idle_err", 32'(err), 0);
      chk("t4_idle_done", 32'(m0_done), 0);
      chk("t4_idle_sreq", 32'(s_req), 0);

      // 4b: rvalid on the watchdog's last cycle wins
      drive1(1, 0, 32'h304, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(); settle();
         chk("t4b_busy_sreq", 32'(s_req), 1);
      end
      cyc();
      slave(1, 32'h5A5A5A5A); settle();
      chk("t4b_last_sreq", 32'(s_req), 1);
      cyc();
      slave(0, 0); settle();
      chk("t4b_m1_done", 32'(m1_done), 1);
      chk("t4b_err", 32'(err), 0);
      chk("t4b_rdata", m1_rdata, 32'h5A5A5A5A);
      drive1(0, 0, 0, 0);
      cyc();

      // 5: reset while BUSY
      drive0(1, 0, 32'h500, 0);
      cyc(); settle();
      chk("t5_busy_sreq", 32'(s_req), 1);
      chk("t5_busy_addr", s_addr, 32'h500);
      rst = 1;
      cyc();
      rst = 0;
      drive1(1, 0, 32'h504, 0); settle();
      chk("t5_after_rst_sreq", 32'(s_req), 0);
      chk("t5_after_rst_m0_done", 32'(m0_done), 0);
      chk("t5_after_rst_m1_done", 32'(m1_done), 0);
      chk("t5_after_rst_err", 32'(err), 0);
      chk("t5_after_rst_hold", 32'(hold_flag), 1);
      cyc();
      slave(1, 32'h13572468); settle();
      chk("t5_tie_gnt_m0_addr", s_addr, 32'h500);
      cyc();
      slave(0, 0); settle();
      chk("t5_m0_done", 32'(m0_done), 1);
      chk("t5_m0_rdata", m0_rdata, 32'h13572468);
      chk("t5_m1_done", 32'(m1_done), 0);
      drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
      cyc();

      // 6: M1 owns the port while M0 waits
      drive1(1, 0, 32'h600, 0); settle();
      chk("t6_idle_hold", 32'(hold_flag), 0);
      cyc();
      drive0(1, 1, 32'h604, 32'h77); settle();
      chk("t6_busy1_hold", 32'(hold_flag), 1);
      chk("t6_busy1_addr", s_addr, 32'h600);
      cyc();
      slave(1, 32'h600DDA7A); settle();
      chk("t6_busy2_hold", 32'(hold_flag), 1);
      chk("t6_busy2_sreq", 32'(s_req), 1);
      cyc();
      slave(0, 0); settle();
      chk("t6_resp_m1_done", 32'(m1_done), 1);
      chk("t6_resp_m1_rdata", m1_rdata, 32'h600DDA7A);
      chk("t6_resp_m0_done", 32'(m0_done), 0);
      chk("t6_resp_m0_rdata", m0_rdata, 0);
      chk("t6_resp_hold", 32'(hold_flag), 1);
      drive1(0, 0, 0, 0);
      cyc(); settle();
      chk("t6_idle2_hold", 32'(hold_flag), 1);
      chk("t6_idle2_sreq", 32'(s_req), 0);
      cyc();
      slave(1, 32'h0000EEEE); settle();
      chk("t6_m0_addr", s_addr, 32'h604);
      chk("t6_m0_we", 32'(s_we), 1);
      chk("t6_m0_wdata", s_wdata, 32'h77);
      chk("t6_m0_busy_hold", 32'(hold_flag), 1);
      cyc();
      slave(0, 0); settle();
      chk("t6_m0_done", 32'(m0_done), 1);
      chk("t6_m0_rdata_wr", m0_rdata, 0);
      chk("t6_m0_resp_hold", 32'(hold_flag), 0);
      drive0(0, 0, 0, 0);
      cyc(); settle();
      chk("t6_end_hold", 32'(hold_flag), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
